// File: rtl/wall_follower_ctrl_if.sv
// Sensor/command bundle between the robot sensor front-end, the wall-following
// controller and the drive unit.
interface wall_follower_ctrl_if;
  logic       enable;
  logic       head;
  logic       left;
  logic       right;
  logic       side_sel;
  logic       front;
  logic       rotate;
  logic       rot_dir;
  logic       stuck;
  logic [2:0] state;

  modport master (
    output enable, head, left, right, side_sel,
    input  front, rotate, rot_dir, stuck, state
  );

  modport slave (
    input  enable, head, left, right, side_sel,
    output front, rotate, rot_dir, stuck, state
  );
endinterface

// File: rtl/wall_follower_ctrl.sv
// Wall-following controller: debounced sensors, left/right wall selection,
// timed corner handling and rotation timeout detection. Outputs decode registers only.
module wall_follower_ctrl #(
  parameter int DEB_CYCLES   = 2,
  parameter int ROT_MAX      = 8,
  parameter int CORNER_STEPS = 2
) (
  input logic                  clk,
  input logic                  reset,
  wall_follower_ctrl_if.slave  bus
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int CNT_W = $clog2(CORNER_STEPS + ROT_MAX);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ROT_LAST    = CNT_W'(ROT_MAX - 1);
  localparam logic [CNT_W-1:0] CORNER_FWD  = CNT_W'(CORNER_STEPS);
  localparam logic [CNT_W-1:0] CORNER_LAST = CNT_W'(CORNER_STEPS + ROT_MAX - 1);

  typedef enum logic [2:0] {
    SEARCH = 3'b000,
    FOLLOW = 3'b001,
    ROTATE = 3'b010,
    CORNER = 3'b011,
    HALT   = 3'b100
  } state_t;

  state_t                  state_q, next_state;
  logic [CNT_W-1:0]        cnt_q, next_cnt;
  logic                    active_q;
  logic [2:0]              raw, filt;
  logic [2:0][DEB_W-1:0]   deb_cnt;
  logic                    h, w;

  assign raw = {bus.right, bus.left, bus.head};
  assign h   = filt[0];
  assign w   = bus.side_sel ? filt[2] : filt[1];

  // Debounce filters run whether or not the controller is enabled.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt    <= '0;
      deb_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (raw[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt[i]    <= raw[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEARCH;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= next_state;
      cnt_q    <= next_cnt;
      active_q <= bus.enable;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    logic cnt_inc;
    next_state = state_q;
    cnt_inc    = 1'b0;
    case (state_q)
      SEARCH: begin
        if (h)      next_state = ROTATE;
        else if (w) next_state = FOLLOW;
      end
      FOLLOW: begin
        if (h)       next_state = ROTATE;
        else if (!w) next_state = CORNER;
      end
      ROTATE: begin
        if (!h && w)                next_state = FOLLOW;
        else if (cnt_q == ROT_LAST) next_state = HALT;
        else                        cnt_inc    = 1'b1;
      end
      CORNER: begin
        if (h)                         next_state = ROTATE;
        else if (w)                    next_state = FOLLOW;
        else if (cnt_q == CORNER_LAST) next_state = SEARCH;
        else                           cnt_inc    = 1'b1;
      end
      HALT:    next_state = HALT;
      default: next_state = SEARCH;
    endcase

    if (!bus.enable) next_state = SEARCH;

    if (next_state != state_q) next_cnt = '0;
    else if (cnt_inc)          next_cnt = cnt_q + CNT_W'(1);
    else                       next_cnt = cnt_q;
  end

  // Motion is gated by the registered enable so idle/reset cycles drive nothing.
  always_comb begin
    bus.front   = 1'b0;
    bus.rotate  = 1'b0;
    bus.rot_dir = 1'b0;
    bus.stuck   = (state_q == HALT);
    bus.state   = state_q;
    if (active_q) begin
      case (state_q)
        SEARCH, FOLLOW: bus.front = 1'b1;
        ROTATE:         bus.rotate = 1'b1;
        CORNER: begin
          if (cnt_q < CORNER_FWD) begin
            bus.front = 1'b1;
          end else begin
            bus.rotate  = 1'b1;
            bus.rot_dir = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wall_follower_ctrl.sv
// Scoreboard bench for wall_follower_ctrl: a behavioural model pushes expected
// outputs per edge; they are popped and compared after the edge.
module tb_wall_follower_ctrl;

  localparam int DEB = 2;
  localparam int RM  = 8;
  localparam int CS  = 2;

  typedef struct packed {
    logic [2:0] state;
    logic       front;
    logic       rotate;
    logic       rot_dir;
    logic       stuck;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // Behavioural model state
  logic [2:0] m_state;
  int         m_cnt;
  bit         m_active;
  bit   [2:0] m_filt;
  bit   [1:0] m_hist [3];

  always #5 clk = ~clk;

  wall_follower_ctrl_if bus ();

  wall_follower_ctrl #(
    .DEB_CYCLES  (DEB),
    .ROT_MAX     (RM),
    .CORNER_STEPS(CS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advances the model across one rising edge using the inputs currently driven.
  task automatic model_advance();
    bit         h, w;
    bit   [2:0] raw;
    logic [2:0] ns;
    int         nc;
    raw = {bus.right, bus.left, bus.head};
    if (reset) begin
      m_state  = 3'b000;
      m_cnt    = 0;
      m_active = 1'b0;
      m_filt   = '0;
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
      return;
    end
    h  = m_filt[0];
    w  = bus.side_sel ? m_filt[2] : m_filt[1];
    ns = m_state;
    case (m_state)
      3'b000: if (h) ns = 3'b010; else if (w) ns = 3'b001;
      3'b001: if (h) ns = 3'b010; else if (!w) ns = 3'b011;
      3'b010: if (!h && w) ns = 3'b001; else if (m_cnt == RM - 1) ns = 3'b100;
      3'b011: if (h) ns = 3'b010; else if (w) ns = 3'b001;
              else if (m_cnt == CS + RM - 1) ns = 3'b000;
      3'b100: ns = 3'b100;
      default: ns = 3'b000;
    endcase
    if (!bus.enable) ns = 3'b000;
    if (ns != m_state)                            nc = 0;
    else if (m_state == 3'b010 || m_state == 3'b011) nc = m_cnt + 1;
    else                                          nc = m_cnt;
    m_state  = ns;
    m_cnt    = nc;
    m_active = bus.enable;
    // A filter flips once its last DEB raw samples all disagree with it.
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][0], raw[i]};
      if (m_hist[i] == {2{~m_filt[i]}}) m_filt[i] = ~m_filt[i];
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.state   = m_state;
    e.stuck   = (m_state == 3'b100);
    e.front   = m_active && (m_state == 3'b000 || m_state == 3'b001 ||
                             (m_state == 3'b011 && m_cnt < CS));
    e.rotate  = m_active && (m_state == 3'b010 || (m_state == 3'b011 && m_cnt >= CS));
    e.rot_dir = m_active && m_state == 3'b011 && m_cnt >= CS;
    return e;
  endfunction

  task automatic step();
    exp_t e;
    model_advance();
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_state",   bus.state,   e.state);
    check("sb_front",   bus.front,   e.front);
    check("sb_rotate",  bus.rotate,  e.rotate);
    check("sb_rot_dir", bus.rot_dir, e.rot_dir);
    check("sb_stuck",   bus.stuck,   e.stuck);
    check("sb_excl",    bus.front & bus.rotate, 0);
  endtask

  task automatic wait_state(input logic [2:0] target, input string tag);
    for (int i = 0; i < 16 && bus.state !== target; i++) step();
    check(tag, bus.state, target);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.enable = 1'b0; bus.head = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.side_sel = 1'b0;
    m_state = '0; m_cnt = 0; m_active = 1'b0; m_filt = '0;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;

    // Reset and first enabled edge
    step(); step();
    check("rst_front", bus.front, 0);
    check("rst_state", bus.state, 0);
    reset = 1'b0; bus.enable = 1'b1;
    step();
    check("en_front", bus.front, 1);
    check("en_state", bus.state, 0);

    // Debounce: short pulse ignored, held head reaches ROTATE after DEB+1 edges
    bus.head = 1'b1; step();
    bus.head = 1'b0; repeat (4) step();
    check("glitch_state", bus.state, 0);
    bus.head = 1'b1; step(); step();
    check("deb_early", bus.state, 0);
    step();
    check("deb_rot_state", bus.state, 3'b010);
    check("deb_rotate", bus.rotate, 1);
    check("deb_rot_dir", bus.rot_dir, 0);

    // Follow then corner on the left wall
    bus.head = 1'b0; bus.left = 1'b1;
    wait_state(3'b001, "to_follow");
    bus.left = 1'b0;
    wait_state(3'b011, "to_corner");
    check("corner_fwd0", bus.front, 1);
    step();
    check("corner_fwd1", bus.front, 1);
    step();
    check("corner_turn", bus.rotate, 1);
    check("corner_dir", bus.rot_dir, 1);
    bus.left = 1'b1;
    wait_state(3'b001, "corner_back");
    check("corner_back_front", bus.front, 1);

    // Rotation timeout into HALT
    bus.head = 1'b1; bus.left = 1'b0;
    wait_state(3'b010, "to_rotate");
    n = 0;
    for (int i = 0; i < 20 && bus.state == 3'b010; i++) begin
      n++;
      step();
    end
    check("rot_cycles", n, RM);
    check("halt_state", bus.state, 3'b100);
    check("halt_stuck", bus.stuck, 1);
    check("halt_front", bus.front, 0);
    check("halt_rotate", bus.rotate, 0);
    bus.head = 1'b0;
    repeat (3) step();
    check("halt_hold", bus.state, 3'b100);
    bus.enable = 1'b0;
    step();
    check("idle_state", bus.state, 0);
    check("idle_stuck", bus.stuck, 0);
    check("idle_front", bus.front, 0);

    // Right-wall mode
    bus.enable = 1'b1; bus.side_sel = 1'b1; bus.right = 1'b1;
    wait_state(3'b001, "right_follow");
    bus.left = 1'b1; repeat (3) step();
    bus.left = 1'b0; repeat (4) step();
    check("right_ignore_left", bus.state, 3'b001);
    bus.right = 1'b0;
    wait_state(3'b011, "right_corner");

    // Corner give-up after CS+RM cycles
    n = 0;
    for (int i = 0; i < 30 && bus.state == 3'b011; i++) begin
      n++;
      step();
    end
    check("corner_cycles", n, CS + RM);
    check("giveup_state", bus.state, 0);
    check("giveup_stuck", bus.stuck, 0);

    // Head and wall rising together in CORNER: head wins
    bus.right = 1'b1;
    wait_state(3'b001, "prio_follow");
    bus.right = 1'b0;
    wait_state(3'b011, "prio_corner");
    bus.head = 1'b1; bus.right = 1'b1;
    for (int i = 0; i < 10 && bus.state == 3'b011; i++) step();
    check("prio_state", bus.state, 3'b010);
    check("prio_rotate", bus.rotate, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
